sbox_share_sched: RTL

//  Time-multiplexes LANES sub_table S-box instances between two requesters: the data path
//  (128-bit SubBytes) and key expansion (32-bit SubWord). Non-preemptive round-robin

---
 rtl/sbox_share_sched.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sbox_share_sched.sv
`timescale 1ns/1ps
// sbox_share_sched: LANES AES S-box lanes shared between a 128-bit SubBytes job and a
// 32-bit SubWord job, non-preemptive round-robin. Define SBOX_SHARE_PIPE_EN to register lane outputs.

module sub_table (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the field inverse, and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] e;
        r = 8'h01;
        e = 8'hfe;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (e[i]) r = gmul(r, x);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv = ginv(a);
        y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module sbox_share_sched #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         d_in_valid,
    output logic         d_in_ready,
    input  logic [127:0] d_in,
    output logic         d_out_valid,
    input  logic         d_out_ready,
    output logic [127:0] d_out,
    input  logic         k_in_valid,
    output logic         k_in_ready,
    input  logic [31:0]  k_in,
    output logic         k_out_valid,
    input  logic         k_out_ready,
    output logic [31:0]  k_out
);
    localparam int NBEAT_D = 16 / LANES;
    localparam int NBEAT_K = 4 / LANES;
    localparam int CW      = $clog2(16 / LANES) + 1;
    localparam logic [CW-1:0] LAST_D = CW'(NBEAT_D - 1);
    localparam logic [CW-1:0] LAST_K = CW'(NBEAT_K - 1);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
            $error("sbox_share_sched: LANES must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                 state, state_nx;
    logic                   owner;      // 1 = key job
    logic                   last_key;
    logic [CW-1:0]          cnt;
    logic [15:0][7:0]       job_b;
    logic [15:0][7:0]       d_res;
    logic [3:0][7:0]        k_res;
    logic [LANES-1:0][3:0]  bidx;
    logic [LANES-1:0][3:0]  widx;
    logic [LANES-1:0][7:0]  lane_in;
    logic [LANES-1:0][7:0]  lane_out;
    logic                   wr_en;
    logic [CW-1:0]          wr_cnt;
    logic [LANES-1:0][7:0]  wr_dat;
    logic                   last_beat;

    // byte 0 sits in the top byte of both request words
    assign d_in_ready  = rst_n && (state == IDLE) && d_in_valid && (!k_in_valid || last_key);
    assign k_in_ready  = rst_n && (state == IDLE) && k_in_valid && (!d_in_valid || !last_key);
    assign d_out_valid = (state == DONE) && !owner;
    assign k_out_valid = (state == DONE) && owner;
    assign d_out       = d_res;
    assign k_out       = k_res;
    assign last_beat   = (cnt == (owner ? LAST_K : LAST_D));

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign bidx[l]    = 4'(cnt * LANES + l);
            assign widx[l]    = 4'(wr_cnt * LANES + l);
            assign lane_in[l] = job_b[4'd15 - bidx[l]];
            sub_table u_sbox (.a(lane_in[l]), .y(lane_out[l]));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (d_in_ready || k_in_ready) state_nx = RUN;
            RUN:   if (last_beat) begin
`ifdef SBOX_SHARE_PIPE_EN
                       state_nx = FLUSH;
`else
                       state_nx = DONE;
`endif
                   end
            FLUSH: state_nx = DONE;
            DONE:  if (owner ? k_out_ready : d_out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= 1'b0;
            last_key <= 1'b1;
            cnt      <= '0;
            job_b    <= '0;
        end else if (state == IDLE) begin
            if (d_in_ready) begin
                job_b    <= d_in;
                owner    <= 1'b0;
                last_key <= 1'b0;
                cnt      <= '0;
            end else if (k_in_ready) begin
                job_b    <= {k_in, 96'h0};
                owner    <= 1'b1;
                last_key <= 1'b1;
                cnt      <= '0;
            end
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef SBOX_SHARE_PIPE_EN
    // write-back trails the lane lookup by one beat; FLUSH drains the last one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en  <= 1'b0;
            wr_cnt <= '0;
            wr_dat <= '0;
        end else begin
            wr_en  <= (state == RUN);
            wr_cnt <= cnt;
            wr_dat <= lane_out;
        end
    end
`else
    assign wr_en  = (state == RUN);
    assign wr_cnt = cnt;
    assign wr_dat = lane_out;
`endif

    // only the owner's result bytes move; the other result keeps its last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_res <= '0;
            k_res <= '0;
        end else if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (owner) k_res[2'd3 - widx[l][1:0]] <= wr_dat[l];
                else       d_res[4'd15 - widx[l]]     <= wr_dat[l];
            end
        end
    end
endmodule
